// File: rtl/vec_strided_lsu.sv
// Strided vector load/store engine: walks vl elements from base_addr by a signed byte stride, one word access each.
// Latency: 3 cycles per element with a 1-cycle responder (ISSUE, ISSUE, COMMIT), plus one DONE cycle.
// Backpressure: holds mem_valid and the request fields stable until mem_ready; a COMMIT gap separates requests.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   start, is_store, base_addr,     operation request (sampled only in IDLE) and its parameters,
//   stride, sew, vl                 all latched on start
//   busy, done, err                 status; err is qualified by done
//   mem_valid/mem_ready/mem_addr/   word-wide memory initiator port; mem_ready is a one-cycle
//   mem_wdata/mem_wstrb/mem_rdata   response strobe carrying mem_rdata
//   vrf_we/vrf_idx/vrf_wdata/       vector register file port; vrf_rdata is combinational
//   vrf_rdata                       from vrf_idx

module vec_strided_lsu #(
    parameter  int VLMAX = 32,
    localparam int IDXW  = $clog2(VLMAX),
    localparam int VLW   = $clog2(VLMAX + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            is_store,
    input  logic [31:0]     base_addr,
    input  logic [31:0]     stride,
    input  logic [1:0]      sew,
    input  logic [VLW-1:0]  vl,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic [31:0]     mem_rdata,
    output logic            vrf_we,
    output logic [IDXW-1:0] vrf_idx,
    output logic [31:0]     vrf_wdata,
    input  logic [31:0]     vrf_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_COMMIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [31:0]    cur_addr;
    logic [31:0]    stride_q;
    logic [1:0]     sew_q;
    logic [VLW-1:0] vl_q;
    logic [VLW-1:0] k;
    logic           is_store_q;
    logic           err_q;
    logic [31:0]    rdata_q;

    // Element-size alignment check on the low address bits; sew8 is never misaligned.
    function automatic logic misaligned(input logic [1:0] s, input logic [1:0] a);
        return ((s == 2'd1) && a[0]) || ((s == 2'd2) && (a != 2'b00));
    endfunction

    logic [31:0] next_addr;
    logic        last_elem;
    logic        start_bad;
    logic        next_bad;

    assign next_addr = cur_addr + stride_q;
    assign last_elem = (k + VLW'(1)) == vl_q;
    assign start_bad = (sew == 2'd3) || misaligned(sew, base_addr[1:0]);
    assign next_bad  = misaligned(sew_q, next_addr[1:0]);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (vl == '0)       state_nxt = S_DONE;
                    else if (start_bad) state_nxt = S_DONE;
                    else                state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_ready) state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                // Completion takes priority: a bad address past the last element is irrelevant.
                if (last_elem)     state_nxt = S_DONE;
                else if (next_bad) state_nxt = S_DONE;
                else               state_nxt = S_ISSUE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_valid = 1'b0;
        vrf_we    = 1'b0;
        case (state)
            S_IDLE: ;
            S_ISSUE: begin
                busy      = 1'b1;
                mem_valid = 1'b1;
            end
            S_COMMIT: begin
                busy   = 1'b1;
                vrf_we = !is_store_q;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    // Operation context and element walker
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr   <= '0;
            stride_q   <= '0;
            sew_q      <= '0;
            vl_q       <= '0;
            k          <= '0;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_addr   <= base_addr;
                        stride_q   <= stride;
                        sew_q      <= sew;
                        vl_q       <= vl;
                        k          <= '0;
                        is_store_q <= is_store;
                        // An empty vector completes cleanly even with bad sew/alignment.
                        err_q      <= (vl != '0) && start_bad;
                    end
                end
                S_ISSUE: begin
                    if (mem_ready) rdata_q <= mem_rdata;
                end
                S_COMMIT: begin
                    k        <= k + VLW'(1);
                    cur_addr <= next_addr;
                    if (!last_elem && next_bad) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr = {cur_addr[31:2], 2'b00};
    assign vrf_idx  = k[IDXW-1:0];

    // Store lane steering; driven only while a store request is outstanding so the
    // port idles at zero (including straight out of reset).
    always_comb begin
        mem_wdata = '0;
        mem_wstrb = '0;
        if ((state == S_ISSUE) && is_store_q) begin
            case (sew_q)
                2'd0: begin
                    mem_wdata = {4{vrf_rdata[7:0]}};
                    mem_wstrb = 4'b0001 << cur_addr[1:0];
                end
                2'd1: begin
                    mem_wdata = {2{vrf_rdata[15:0]}};
                    mem_wstrb = 4'b0011 << cur_addr[1:0];
                end
                default: begin
                    mem_wdata = vrf_rdata;
                    mem_wstrb = 4'b1111;
                end
            endcase
        end
    end

    // Load lane extraction from the captured response word, zero-extended.
    always_comb begin
        vrf_wdata = '0;
        case (sew_q)
            2'd0:    vrf_wdata = {24'b0, rdata_q[{cur_addr[1:0], 3'b000} +: 8]};
            2'd1:    vrf_wdata = {16'b0, rdata_q[{cur_addr[1], 4'b0000} +: 16]};
            default: vrf_wdata = rdata_q;
        endcase
    end

endmodule

// File: tb/tb_vec_strided_lsu.sv
module tb_vec_strided_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] stride = '0;
    logic [1:0]  sew = '0;
    logic [5:0]  vl = '0;
    logic        busy, done, err;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        vrf_we;
    logic [4:0]  vrf_idx;
    logic [31:0] vrf_wdata;
    logic [31:0] vrf_rdata;

    logic [31:0] vrf [0:31];
    logic [31:0] mem [0:1023];

    assign vrf_rdata = vrf[vrf_idx];

    vec_strided_lsu #(.VLMAX(32)) dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store),
        .base_addr(base_addr), .stride(stride), .sew(sew), .vl(vl),
        .busy(busy), .done(done), .err(err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .vrf_we(vrf_we), .vrf_idx(vrf_idx), .vrf_wdata(vrf_wdata), .vrf_rdata(vrf_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    int wcnt = 0;
    int lat = 1;
    bit rand_lat = 0;
    bit noise = 0;

    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (mem_valid) begin
            if (wcnt >= lat) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[11:2]];
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
            lat  = rand_lat ? int'($urandom_range(1, 3)) : 1;
            if (noise) begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [31:0] req_addr[$], req_wdata[$];
    logic [3:0]  req_strb[$];
    int          req_cyc[$];
    logic [4:0]  we_idx[$];
    logic [31:0] we_dat[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        done_err = 1'b0;
    int          stab_bad = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_strb;

    always @(negedge clk) begin
        if (mem_valid && !prev_valid) begin
            req_addr.push_back(mem_addr);
            req_wdata.push_back(mem_wdata);
            req_strb.push_back(mem_wstrb);
            req_cyc.push_back(cyc);
            last_addr  = mem_addr;
            last_wdata = mem_wdata;
            last_strb  = mem_wstrb;
        end else if (mem_valid) begin
            if (mem_addr !== last_addr || mem_wdata !== last_wdata || mem_wstrb !== last_strb)
                stab_bad++;
        end
        prev_valid = mem_valid;
        if (vrf_we) begin
            we_idx.push_back(vrf_idx);
            we_dat.push_back(vrf_wdata);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = err;
        end
    end

    task automatic clear_obs();
        req_addr.delete(); req_wdata.delete(); req_strb.delete(); req_cyc.delete();
        we_idx.delete(); we_dat.delete();
        done_cnt = 0;
        stab_bad = 0;
    endtask

    // ---------------- reference model ----------------
    logic [31:0] e_addr[$], e_wdata[$], e_dat[$];
    logic [3:0]  e_strb[$];
    int          e_idx[$];
    int          e_n;
    bit          e_err;

    function automatic bit misal(input logic [31:0] a, input logic [1:0] sw);
        return (sw == 2'd1 && (a % 2) != 0) || (sw == 2'd2 && (a % 4) != 0);
    endfunction

    task automatic model(input bit st, input logic [31:0] b, input logic [31:0] s,
                         input logic [1:0] sw, input int n);
        logic [31:0] a, off, mask, val, w;
        int esz;
        e_addr.delete(); e_wdata.delete(); e_dat.delete(); e_strb.delete(); e_idx.delete();
        e_n = 0;
        e_err = 0;
        if (n == 0) return;
        if (sw == 2'd3) begin e_err = 1; return; end
        esz  = 1 << sw;
        mask = (esz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * esz)) - 1);
        for (int i = 0; i < n; i++) begin
            a = b + s * 32'(i);
            if (misal(a, sw)) begin e_err = 1; return; end
            e_n++;
            off = a % 4;
            e_addr.push_back(a - off);
            if (st) begin
                val = vrf[i] & mask;
                w = 0;
                for (int j = 0; j < 4 / esz; j++) w = w | (val << (8 * esz * j));
                e_wdata.push_back(w);
                e_strb.push_back(4'(((1 << esz) - 1) << off));
            end else begin
                e_wdata.push_back(0);
                e_strb.push_back(4'd0);
                e_idx.push_back(i);
                e_dat.push_back((mem[a[11:2]] >> (8 * off)) & mask);
            end
        end
    endtask

    // ---------------- operation driver + checker ----------------
    int t0 = 0;

    task automatic run_op(input string tag, input bit st, input logic [31:0] b,
                          input logic [31:0] s, input logic [1:0] sw, input int n,
                          input bit timed, input bit busy_start);
        int w;
        model(st, b, s, sw, n);
        @(negedge clk);
        clear_obs();
        start = 1; is_store = st; base_addr = b; stride = s; sew = sw; vl = 6'(n);
        t0 = cyc;
        @(negedge clk);
        start = 0;
        // scramble the request inputs to show they were latched
        is_store = 1'($urandom); base_addr = $urandom; stride = $urandom; sew = 2'($urandom); vl = 6'($urandom);
        w = 0;
        while (done_cnt == 0 && w < 2000) begin
            start = (busy_start && w == 1);
            @(negedge clk);
            w++;
        end
        start = 0;
        repeat (4) @(negedge clk);
        chk({tag, ".done_cnt"}, done_cnt, 1);
        chk({tag, ".err"}, 32'(done_err), 32'(e_err));
        chk({tag, ".busy_after"}, 32'(busy), 0);
        if (timed) chk({tag, ".done_cyc"}, done_cyc - t0, 3 * e_n + 1);
        chk({tag, ".req_cnt"}, req_addr.size(), e_n);
        for (int k = 0; k < e_n && k < req_addr.size(); k++) begin
            chk($sformatf("%s.addr[%0d]", tag, k), req_addr[k], e_addr[k]);
            chk($sformatf("%s.strb[%0d]", tag, k), 32'(req_strb[k]), 32'(e_strb[k]));
            if (st) chk($sformatf("%s.wdata[%0d]", tag, k), req_wdata[k], e_wdata[k]);
            if (timed) chk($sformatf("%s.req_cyc[%0d]", tag, k), req_cyc[k] - t0, 3 * k + 1);
        end
        chk({tag, ".stable"}, stab_bad, 0);
        chk({tag, ".we_cnt"}, we_idx.size(), e_idx.size());
        for (int k = 0; k < e_idx.size() && k < we_idx.size(); k++) begin
            chk($sformatf("%s.we_idx[%0d]", tag, k), 32'(we_idx[k]), e_idx[k]);
            chk($sformatf("%s.we_dat[%0d]", tag, k), we_dat[k], e_dat[k]);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          st;
        logic [1:0]  sw;
        logic [31:0] b, s;
        int          n, esz;

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int i = 0; i < 32; i++) vrf[i] = $urandom | 32'h0101_0101;

        // ---- reset state ----
        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.err", 32'(err), 0);
        chk("rst.mem_valid", 32'(mem_valid), 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.mem_wdata", mem_wdata, 0);
        chk("rst.mem_wstrb", 32'(mem_wstrb), 0);
        chk("rst.vrf_we", 32'(vrf_we), 0);
        chk("rst.vrf_idx", 32'(vrf_idx), 0);
        chk("rst.vrf_wdata", vrf_wdata, 0);

        // ---- directed: sew8 unit stride load ----
        mem[100] = 32'h0403_0201; mem[101] = 32'h0807_0605; mem[102] = 32'h0C0B_0A09;
        run_op("ld8_s1", 0, 32'd400, 32'd1, 2'd0, 4, 1, 0);
        chk("ld8_s1.done_at_13", done_cyc - t0, 13);
        if (we_dat.size() == 4) begin
            chk("ld8_s1.v0", we_dat[0], 32'h01);
            chk("ld8_s1.v3", we_dat[3], 32'h04);
        end

        // ---- directed: sew8 stride 3 load ----
        run_op("ld8_s3", 0, 32'd400, 32'd3, 2'd0, 4, 1, 0);
        if (req_addr.size() == 4) begin
            chk("ld8_s3.a1", req_addr[1], 32'd400);
            chk("ld8_s3.a3", req_addr[3], 32'd408);
        end
        if (we_dat.size() == 4) chk("ld8_s3.v3", we_dat[3], 32'h0A);

        // ---- directed: sew16 load, aligned and misaligned base ----
        run_op("ld16", 0, 32'd402, 32'd4, 2'd1, 2, 1, 0);
        if (we_dat.size() == 2) begin
            chk("ld16.v0", we_dat[0], 32'h0403);
            chk("ld16.v1", we_dat[1], 32'h0807);
        end
        run_op("ld16_mis", 0, 32'd401, 32'd4, 2'd1, 2, 1, 0);
        chk("ld16_mis.err1", 32'(done_err), 1);

        // ---- directed: sew8 store, negative stride ----
        vrf[0] = 32'h1234_56AA; vrf[1] = 32'h0000_00BB; vrf[2] = 32'hFFFF_FFCC;
        run_op("st8_neg", 1, 32'd600, 32'hFFFF_FFFF, 2'd0, 3, 1, 0);
        if (req_addr.size() == 3) begin
            chk("st8_neg.a1", req_addr[1], 32'd596);
            chk("st8_neg.s1", 32'(req_strb[1]), 32'h8);
            chk("st8_neg.s2", 32'(req_strb[2]), 32'h4);
            chk("st8_neg.w0", req_wdata[0], 32'hAAAA_AAAA);
        end

        // ---- directed: vl=0, reserved sew, mid-stream misalign, stride 0, wrap ----
        run_op("vl0", 0, 32'd401, 32'd4, 2'd3, 0, 1, 0);
        run_op("sew3", 1, 32'd400, 32'd4, 2'd3, 5, 1, 0);
        run_op("mis_mid", 0, 32'd400, 32'd6, 2'd2, 5, 1, 0);
        run_op("stride0", 1, 32'd800, 32'd0, 2'd1, 3, 1, 0);
        run_op("wrap", 0, 32'd4, 32'hFFFF_FFFC, 2'd2, 4, 1, 0);

        // ---- start while busy is ignored ----
        run_op("busy_start", 0, 32'd400, 32'd4, 2'd2, 3, 1, 1);

        // ---- reset during element 2 ISSUE of a vl=8 load ----
        @(negedge clk);
        clear_obs();
        start = 1; is_store = 0; base_addr = 32'h100; stride = 32'd4; sew = 2'd2; vl = 6'd8;
        t0 = cyc;
        @(negedge clk);
        start = 0;
        repeat (6) @(negedge clk);
        chk("midrst.pre_valid", 32'(mem_valid), 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("midrst.valid", 32'(mem_valid), 0);
        chk("midrst.busy", 32'(busy), 0);
        chk("midrst.done", 32'(done), 0);
        repeat (20) @(negedge clk);
        chk("midrst.we_cnt", we_idx.size(), 2);
        chk("midrst.req_cnt", req_addr.size(), 3);
        chk("midrst.done_cnt", done_cnt, 0);
        run_op("after_rst", 0, 32'h200, 32'd4, 2'd2, 4, 1, 0);

        // ---- randomized operations with variable latency and stray ready ----
        rand_lat = 1;
        noise = 1;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 32; i++) vrf[i] = $urandom;
            st = 1'($urandom);
            sw = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            n  = $urandom_range(0, 32);
            b  = $urandom;
            s  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
            if ($urandom_range(0, 9) < 7) begin
                esz = 1 << sw;
                if (sw == 2'd3) esz = 4;
                b = b & ~(32'(esz) - 1);
                s = s * 32'(esz);
            end
            run_op($sformatf("rnd%0d", r), st, b, s, sw, n, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
